// File: rtl/ddr_host_port.sv
// ddr_host_port: client-side front end for the DDR3 controller.
//
// Accepts client requests (req_*) and write words (wr_*) through valid/ready
// handshakes, stages up to 32 write words locally, then drives the controller's
// single-cycle command interface (cmd/addr/sz/op/din). Block writes stream the
// remaining staged words on the cycles right after the command. Issue is held
// off until the controller's input-data FIFO has room for the whole burst and
// the return FIFO cannot be over-subscribed. Returned words are popped with
// read pulses and presented on a single-entry valid/ready response register.
//
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   req_valid/ready/cmd/addr/sz/op  client request channel
//   wr_valid/ready/data         client write-word channel
//   rsp_valid/ready/data/addr   response channel
//   err                         one-cycle pulse on an illegal request command
//   cmd/addr/sz/op/din          controller command interface (cmd 0 = NOP)
//   notfull, fillcount, ctrl_ready  controller flow-control status
//   read, validout, dout, raddr controller return-FIFO interface
module ddr_host_port #(
   parameter int unsigned IN_DEPTH  = 32,
   parameter int unsigned RET_DEPTH = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_cmd,
   input  logic [25:0] req_addr,
   input  logic [1:0]  req_sz,
   input  logic [2:0]  req_op,
   input  logic        wr_valid,
   output logic        wr_ready,
   input  logic [15:0] wr_data,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_data,
   output logic [25:0] rsp_addr,
   output logic        err,
   output logic [2:0]  cmd,
   output logic [25:0] addr,
   output logic [1:0]  sz,
   output logic [2:0]  op,
   output logic [15:0] din,
   input  logic        notfull,
   input  logic [5:0]  fillcount,
   input  logic        ctrl_ready,
   output logic        read,
   input  logic        validout,
   input  logic [15:0] dout,
   input  logic [25:0] raddr
);

   localparam logic [2:0] CmdNop = 3'd0;
   localparam logic [2:0] CmdScr = 3'd1;
   localparam logic [2:0] CmdScw = 3'd2;
   localparam logic [2:0] CmdBlr = 3'd3;
   localparam logic [2:0] CmdBlw = 3'd4;
   localparam logic [2:0] CmdAtr = 3'd5;
   localparam logic [2:0] CmdAtw = 3'd6;

   typedef enum logic [2:0] {StIdle, StCollect, StWait, StIssue, StStream} cmd_state_e;
   typedef enum logic {RIdle, RWait} ret_state_e;

   cmd_state_e  state_q;
   ret_state_e  rstate_q;
   logic [2:0]  lat_cmd_q;
   logic [25:0] lat_addr_q;
   logic [1:0]  lat_sz_q;
   logic [2:0]  lat_op_q;
   logic [5:0]  n_q;
   logic [5:0]  ptr_q;
   logic [6:0]  expected_q;
   logic [15:0] stage [32];

   function automatic logic [5:0] burst_len(input logic [2:0] c, input logic [1:0] s);
      if (c == CmdBlr || c == CmdBlw) return {1'b0, s, 3'b000} + 6'd8;
      return 6'd1;
   endfunction

   // ATR carries its operand word, so it collects like a write.
   function automatic logic carries_write(input logic [2:0] c);
      return (c == CmdScw) || (c == CmdAtw) || (c == CmdAtr) || (c == CmdBlw);
   endfunction

   logic [6:0] ret_cnt;
   logic       fill_ok;
   logic       ret_ok;
   logic       wait_go;
   logic       wr_fire;
   logic       capture;
   logic [6:0] exp_inc;

   always_comb begin
      ret_cnt = 7'd0;
      if (lat_cmd_q == CmdBlr) ret_cnt = {1'b0, n_q};
      else if (lat_cmd_q == CmdScr || lat_cmd_q == CmdAtr) ret_cnt = 7'd1;
   end

   // fillcount + N <= depth is the same test as fillcount <= depth - N without underflow.
   assign fill_ok = !carries_write(lat_cmd_q) ||
                    (({26'd0, fillcount} + {26'd0, n_q}) <= IN_DEPTH);
   assign ret_ok  = (ret_cnt == 7'd0) ||
                    (({25'd0, expected_q} + {25'd0, ret_cnt}) <= RET_DEPTH);
   assign wait_go = ctrl_ready && notfull && fill_ok && ret_ok;
   assign wr_fire = (state_q == StCollect) && wr_valid && wr_ready;

   always_ff @(posedge clk) begin
      if (wr_fire) stage[ptr_q[4:0]] <= wr_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= StIdle;
         req_ready  <= 1'b0;
         wr_ready   <= 1'b0;
         err        <= 1'b0;
         cmd        <= CmdNop;
         addr       <= '0;
         sz         <= '0;
         op         <= '0;
         din        <= '0;
         lat_cmd_q  <= CmdNop;
         lat_addr_q <= '0;
         lat_sz_q   <= '0;
         lat_op_q   <= '0;
         n_q        <= '0;
         ptr_q      <= '0;
      end else begin
         err <= 1'b0;
         cmd <= CmdNop;
         unique case (state_q)
            StIdle: begin
               req_ready <= 1'b1;
               if (req_valid && req_ready) begin
                  lat_cmd_q  <= req_cmd;
                  lat_addr_q <= req_addr;
                  lat_sz_q   <= req_sz;
                  lat_op_q   <= req_op;
                  n_q        <= burst_len(req_cmd, req_sz);
                  ptr_q      <= '0;
                  if (req_cmd == CmdNop || req_cmd == 3'd7) begin
                     err <= 1'b1;
                  end else if (carries_write(req_cmd)) begin
                     state_q   <= StCollect;
                     req_ready <= 1'b0;
                     wr_ready  <= 1'b1;
                  end else begin
                     state_q   <= StWait;
                     req_ready <= 1'b0;
                  end
               end
            end
            StCollect: begin
               if (wr_valid && wr_ready) begin
                  if (ptr_q == n_q - 6'd1) begin
                     ptr_q    <= '0;
                     wr_ready <= 1'b0;
                     state_q  <= StWait;
                  end else begin
                     ptr_q <= ptr_q + 6'd1;
                  end
               end
            end
            StWait: begin
               if (wait_go) begin
                  state_q <= StIssue;
                  cmd     <= lat_cmd_q;
                  addr    <= lat_addr_q;
                  sz      <= lat_sz_q;
                  op      <= lat_op_q;
                  din     <= stage[0];
               end
            end
            StIssue: begin
               if (lat_cmd_q == CmdBlw) begin
                  state_q <= StStream;
                  din     <= stage[1];
                  ptr_q   <= 6'd2;
               end else begin
                  state_q   <= StIdle;
                  req_ready <= 1'b1;
               end
            end
            StStream: begin
               // ptr_q is the index of the word to present next cycle.
               if (ptr_q == n_q) begin
                  state_q   <= StIdle;
                  req_ready <= 1'b1;
                  ptr_q     <= '0;
               end else begin
                  din   <= stage[ptr_q[4:0]];
                  ptr_q <= ptr_q + 6'd1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // read must coincide with the RIDLE decision so validout lands in RWAIT.
   assign read    = (rstate_q == RIdle) && (expected_q != 7'd0) && (!rsp_valid || rsp_ready);
   assign capture = (rstate_q == RWait) && validout;
   assign exp_inc = (state_q == StIssue) ? ret_cnt : 7'd0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rstate_q   <= RIdle;
         expected_q <= '0;
         rsp_valid  <= 1'b0;
         rsp_data   <= '0;
         rsp_addr   <= '0;
      end else begin
         expected_q <= expected_q + exp_inc - {6'd0, capture};
         if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;
         unique case (rstate_q)
            RIdle: begin
               if (read) rstate_q <= RWait;
            end
            RWait: begin
               rstate_q <= RIdle;
               if (validout) begin
                  rsp_data  <= dout;
                  rsp_addr  <= raddr;
                  rsp_valid <= 1'b1;
               end
            end
            default: rstate_q <= RIdle;
         endcase
      end
   end

endmodule

// File: doc/ddr_host_port.md
Name: ddr_host_port

Overview:
- Client-side front end that sits directly upstream of the DDR3 controller.
- Accepts client requests and write words through valid/ready handshakes and stages block-write bursts in a local buffer.
- Drives the controller's one-cycle cmd/addr/sz/op/din interface and streams burst data without ever overflowing the controller's input FIFO.
- Drains the controller's return FIFO with read pulses and presents the data as a valid/ready response stream.

Parameters:
- IN_DEPTH, 32: controller input-data FIFO depth in words.
- RET_DEPTH, 32: controller return FIFO depth; cap on outstanding expected return words.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  client request valid
- req_ready  out  1  request accepted when valid&&ready
- req_cmd  in  3  SCR=1 SCW=2 BLR=3 BLW=4 ATR=5 ATW=6
- req_addr  in  26  request address
- req_sz  in  2  burst size; N=(sz+1)*8 words for BLR/BLW, else N=1
- req_op  in  3  atomic opcode
- wr_valid  in  1  client write word valid
- wr_ready  out  1  write word accepted when valid&&ready
- wr_data  in  16  client write word
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed
- rsp_data  out  16  returned data
- rsp_addr  out  26  returned address
- err  out  1  one-cycle pulse on an illegal req_cmd
- cmd  out  3  controller command; 0 = NOP
- addr  out  26  controller address
- sz  out  2  controller size
- op  out  3  controller opcode
- din  out  16  controller write data
- notfull  in  1  controller command FIFO not full
- fillcount  in  6  controller input-data FIFO occupancy
- ctrl_ready  in  1  controller initialised
- read  out  1  return FIFO pop pulse
- validout  in  1  returned word valid (one cycle after an effective read)
- dout  in  16  returned data
- raddr  in  26  returned address

Behaviour:
- Reset (reset=0, async): all outputs 0, cmd=NOP, FSMs idle, expected=0, stage buffer pointer=0.
- Command FSM states:
  - IDLE: req_ready=1 (registered from state).
    - On handshake, latch cmd/addr/sz/op and compute N (6 bits).
    - Write-carrying commands (SCW, ATW, ATR, BLW) go to COLLECT.
    - SCR and BLR go to WAIT.
    - cmd 0 or 7: drop the request, pulse err, stay in IDLE.
  - COLLECT: wr_ready=1; stage words at index 0..N-1; go to WAIT after word N-1 is accepted.
  - WAIT: proceed to ISSUE only when all of the following hold in the same cycle:
    - ctrl_ready=1 and notfull=1;
    - for write-carrying commands: fillcount <= IN_DEPTH-N;
    - for SCR/BLR/ATR: expected + returns(cmd) <= RET_DEPTH, where returns = N for BLR, 1 for SCR/ATR, 0 otherwise.
  - ISSUE: exactly one cycle.
    - Drive cmd/addr/sz/op, with din = stage[0].
    - expected += returns(cmd).
    - BLW goes to STREAM; all other commands go to IDLE.
  - STREAM: cmd=NOP, din=stage[1..N-1] on consecutive cycles with no gaps (N-1 cycles), then IDLE.
- cmd is NOP in every cycle other than ISSUE; addr/sz/op/din hold their last values.
- Return FSM states:
  - RIDLE: if expected>0 and the response register is empty (or is being consumed this cycle), assert read for one cycle and go to RWAIT.
  - RWAIT: one cycle.
    - If validout=1: capture dout/raddr into the response register, set rsp_valid=1, expected -= 1.
    - If validout=0 (FIFO was empty): no change; return to RIDLE and retry.
- rsp_valid stays high until rsp_ready; the response register is single-entry.
- expected is 7 bits; increment (ISSUE) and decrement (RWAIT capture) in the same cycle apply net.
- ctrl_ready dropping while in WAIT: remain in WAIT. STREAM is never interrupted once started.
- err and read are single-cycle pulses.

Test Plan:
- Reset release, ctrl_ready=1; SCW addr=0x0000100 data=0xA5A5 -> wr_ready one cycle; cmd=2 for exactly 1 cycle with din=0xA5A5; then cmd=0.
- BLW sz=3 with words 0..31 and fillcount=0 -> 32 words collected; cmd=4 for one cycle with din=0; din=1..31 on the next 31 consecutive cycles.
- BLW sz=1 with fillcount=20 -> held in WAIT; lower fillcount to 16 -> ISSUE occurs the next cycle.
- BLR sz=0 with the return model supplying 8 words, rsp_ready held low 3 cycles per word -> 8 responses in order with matching raddr; at most one read pulse in flight; expected returns to 0.
- Read pulse with return model empty (validout=0) -> no response; read retried 2 cycles later.
- req_cmd=7 -> err pulse, no cmd issued. Assert reset mid-STREAM -> cmd=0, read=0, req_ready=0 immediately.
